// File: rtl/cfi_pkg.sv
// Shared types and constants for the landing-pad (forward-edge CFI) controller.
// Holds the FSM encoding, decode constants, exception values and small helpers.
package cfi_pkg;

    localparam int unsigned LABEL_W = 20;

    localparam logic [6:0]  OPC_JALR       = 7'b1100111;
    localparam logic [6:0]  OPC_AUIPC      = 7'b0010111;
    localparam logic [5:0]  CAUSE_SW_CHECK = 6'd18;
    localparam logic [31:0] TVAL_LP_FAULT  = 32'd2;
    localparam logic [15:0] VIOL_CNT_MAX   = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_NO_LP  = 2'd0,
        ST_LP_EXP = 2'd1,
        ST_FAULT  = 2'd2
    } cfi_state_e;

    // Link registers x1/x5/x7 mark returns and call sequences, not indirect jumps.
    function automatic logic is_link_reg(input logic [4:0] r);
        return (r == 5'd1) || (r == 5'd5) || (r == 5'd7);
    endfunction

    // Label 0 is a wildcard landing pad.
    function automatic logic label_match(input logic [LABEL_W-1:0] lpad_label,
                                         input logic [LABEL_W-1:0] x7_label);
        return (lpad_label == {LABEL_W{1'b0}}) || (lpad_label == x7_label);
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == VIOL_CNT_MAX) ? v : (v + 16'd1);
    endfunction

endpackage

// File: rtl/cfi_lp_ctrl_if.sv
// Commit / trap / exception signal bundle between the core and the landing-pad controller.
// slave is the controller's view; master is the core (or bench) view.
interface cfi_lp_ctrl_if;
    import cfi_pkg::*;

    logic               en_i;
    logic               commit_valid_i;
    logic [31:0]        commit_instr_i;
    logic [LABEL_W-1:0] x7_label_i;
    logic               trap_i;
    logic               mret_i;
    logic               ex_ack_i;
    logic               elp_o;
    logic               pelp_o;
    logic               ex_valid_o;
    logic [5:0]         ex_cause_o;
    logic [31:0]        ex_tval_o;
    logic [15:0]        viol_cnt_o;

    modport master (
        output en_i, commit_valid_i, commit_instr_i, x7_label_i, trap_i, mret_i, ex_ack_i,
        input  elp_o, pelp_o, ex_valid_o, ex_cause_o, ex_tval_o, viol_cnt_o
    );

    modport slave (
        input  en_i, commit_valid_i, commit_instr_i, x7_label_i, trap_i, mret_i, ex_ack_i,
        output elp_o, pelp_o, ex_valid_o, ex_cause_o, ex_tval_o, viol_cnt_o
    );

endinterface

// File: rtl/cfi_lp_decode.sv
// Combinational decode of a committed instruction into indirect-jump / landing-pad flags.
module cfi_lp_decode
    import cfi_pkg::*;
(
    input  logic [31:0]        instr,
    output logic               is_ind_jmp,
    output logic               is_lpad,
    output logic [LABEL_W-1:0] lpad_label
);

    logic [6:0] opcode_s;
    logic [4:0] rs1_s;
    logic [4:0] rd_s;
    logic       unused_funct3_s;

    assign opcode_s        = instr[6:0];
    assign rs1_s           = instr[19:15];
    assign rd_s            = instr[11:7];
    assign unused_funct3_s = ^instr[14:12];

    // An LPAD is AUIPC with rd=x0; its upper immediate is the label.
    always_comb begin
        is_ind_jmp = (opcode_s == OPC_JALR) && !is_link_reg(rs1_s);
        is_lpad    = (opcode_s == OPC_AUIPC) && (rd_s == 5'd0);
        lpad_label = instr[31:12];
    end

endmodule

// File: rtl/cfi_lp_ctrl.sv
// Landing-pad enforcement: tracks the expected-landing-pad state across commits,
// traps and trap returns, and raises a software-check exception on a missing pad.
module cfi_lp_ctrl
    import cfi_pkg::*;
#(
    parameter logic [15:0] VIOL_CNT_INIT = 16'h0000
) (
    input  logic          clk_i,
    input  logic          rst_i,
    cfi_lp_ctrl_if.slave  bus
);

    cfi_state_e         state_r;
    cfi_state_e         state_nxt_s;
    logic               pelp_r;
    logic               pelp_nxt_s;
    logic [15:0]        viol_cnt_r;
    logic [15:0]        viol_cnt_nxt_s;
    logic               is_ind_jmp_s;
    logic               is_lpad_s;
    logic [LABEL_W-1:0] lpad_label_s;
    logic               elp_s;
    logic               ex_valid_s;
    logic [5:0]         ex_cause_s;
    logic [31:0]        ex_tval_s;

    cfi_lp_decode u_decode (
        .instr      (bus.commit_instr_i),
        .is_ind_jmp (is_ind_jmp_s),
        .is_lpad    (is_lpad_s),
        .lpad_label (lpad_label_s)
    );

    // State, saved ELP and violation counter registers; reset drops any pending exception.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r    <= ST_NO_LP;
            pelp_r     <= 1'b0;
            viol_cnt_r <= VIOL_CNT_INIT;
        end else begin
            state_r    <= state_nxt_s;
            pelp_r     <= pelp_nxt_s;
            viol_cnt_r <= viol_cnt_nxt_s;
        end
    end

    // Next state: ack (FAULT only) beats trap, trap beats mret, mret beats the commit.
    always_comb begin
        state_nxt_s    = state_r;
        pelp_nxt_s     = pelp_r;
        viol_cnt_nxt_s = viol_cnt_r;
        if (!bus.en_i) begin
            state_nxt_s = ST_NO_LP;
        end else begin
            case (state_r)
                ST_FAULT: begin
                    if (bus.ex_ack_i) begin
                        pelp_nxt_s  = 1'b1;
                        state_nxt_s = ST_NO_LP;
                    end else begin
                        state_nxt_s = ST_FAULT;
                    end
                end
                ST_NO_LP, ST_LP_EXP: begin
                    if (bus.trap_i) begin
                        pelp_nxt_s  = (state_r == ST_LP_EXP);
                        state_nxt_s = ST_NO_LP;
                    end else if (bus.mret_i) begin
                        state_nxt_s = pelp_r ? ST_LP_EXP : ST_NO_LP;
                        pelp_nxt_s  = 1'b0;
                    end else if (bus.commit_valid_i) begin
                        if (state_r == ST_NO_LP) begin
                            state_nxt_s = is_ind_jmp_s ? ST_LP_EXP : ST_NO_LP;
                        end else if (is_lpad_s && label_match(lpad_label_s, bus.x7_label_i)) begin
                            state_nxt_s = ST_NO_LP;
                        end else begin
                            state_nxt_s    = ST_FAULT;
                            viol_cnt_nxt_s = sat_inc16(viol_cnt_r);
                        end
                    end else begin
                        state_nxt_s = state_r;
                    end
                end
                default: begin
                    state_nxt_s = ST_NO_LP;
                end
            endcase
        end
    end

    // Outputs decode straight from the state register, so they change only at clock edges.
    always_comb begin
        elp_s      = 1'b0;
        ex_valid_s = 1'b0;
        ex_cause_s = 6'd0;
        ex_tval_s  = 32'd0;
        case (state_r)
            ST_NO_LP: begin
                elp_s = 1'b0;
            end
            ST_LP_EXP: begin
                elp_s = 1'b1;
            end
            ST_FAULT: begin
                elp_s      = 1'b1;
                ex_valid_s = 1'b1;
                ex_cause_s = CAUSE_SW_CHECK;
                ex_tval_s  = TVAL_LP_FAULT;
            end
            default: begin
                elp_s = 1'b0;
            end
        endcase
    end

    assign bus.elp_o      = elp_s;
    assign bus.pelp_o     = pelp_r;
    assign bus.ex_valid_o = ex_valid_s;
    assign bus.ex_cause_o = ex_cause_s;
    assign bus.ex_tval_o  = ex_tval_s;
    assign bus.viol_cnt_o = viol_cnt_r;

endmodule

// File: tb/tb_cfi_lp_ctrl.sv
// Directed-vector bench for cfi_lp_ctrl: one table-driven run plus a counter saturation sequence.
module tb_cfi_lp_ctrl;
    import cfi_pkg::*;

    localparam logic [31:0] I_JALR6  = 32'h00030067;
    localparam logic [31:0] I_RET    = 32'h00008067;
    localparam logic [31:0] I_JALR5  = 32'h00028067;
    localparam logic [31:0] I_JALR7  = 32'h00038067;
    localparam logic [31:0] I_LPAD   = 32'h12345017;
    localparam logic [31:0] I_LPAD0  = 32'h00000017;
    localparam logic [31:0] I_LPAD1  = 32'h00001017;
    localparam logic [31:0] I_AUIPC5 = 32'h00000297;
    localparam logic [31:0] I_ADDI   = 32'h00000013;
    localparam logic [19:0] LBL      = 20'h12345;

    typedef struct {
        logic        rst;
        logic        en;
        logic        cv;
        logic [31:0] instr;
        logic [19:0] x7;
        logic        trap;
        logic        mret;
        logic        ack;
        logic        e_elp;
        logic        e_pelp;
        logic        e_exv;
        logic [15:0] e_cnt;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic rst_sat;
    int   checks = 0;
    int   errors = 0;
    vec_t vq[$];

    always #5 clk = ~clk;

    cfi_lp_ctrl_if bus ();
    cfi_lp_ctrl_if sbus ();

    cfi_lp_ctrl u_dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    cfi_lp_ctrl #(.VIOL_CNT_INIT(16'hFFFD)) u_sat (
        .clk_i (clk),
        .rst_i (rst_sat),
        .bus   (sbus)
    );

    function automatic vec_t mk(logic r, logic en, logic cv, logic [31:0] ins, logic [19:0] x7,
                                logic tr, logic mr, logic ak,
                                logic elp, logic pelp, logic exv, logic [15:0] cnt);
        vec_t v;
        v.rst = r; v.en = en; v.cv = cv; v.instr = ins; v.x7 = x7;
        v.trap = tr; v.mret = mr; v.ack = ak;
        v.e_elp = elp; v.e_pelp = pelp; v.e_exv = exv; v.e_cnt = cnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Check all six outputs of an instance against an expected state.
    task automatic chk_out(input string tag, input logic elp, input logic pelp, input logic exv,
                           input logic [5:0] cause, input logic [31:0] tval, input logic [15:0] cnt,
                           input logic e_elp, input logic e_pelp, input logic e_exv, input logic [15:0] e_cnt);
        chk({tag, " elp"},   {31'd0, elp},  {31'd0, e_elp});
        chk({tag, " pelp"},  {31'd0, pelp}, {31'd0, e_pelp});
        chk({tag, " exv"},   {31'd0, exv},  {31'd0, e_exv});
        chk({tag, " cause"}, {26'd0, cause}, e_exv ? 32'd18 : 32'd0);
        chk({tag, " tval"},  tval,           e_exv ? 32'd2 : 32'd0);
        chk({tag, " cnt"},   {16'd0, cnt},  {16'd0, e_cnt});
    endtask

    task automatic sstep(input logic cv, input logic [31:0] ins, input logic ak);
        sbus.commit_valid_i = cv;
        sbus.commit_instr_i = ins;
        sbus.ex_ack_i       = ak;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        rst_sat = 1'b1;
        bus.en_i = 1'b1; bus.commit_valid_i = 1'b0; bus.commit_instr_i = I_ADDI;
        bus.x7_label_i = LBL; bus.trap_i = 1'b0; bus.mret_i = 1'b0; bus.ex_ack_i = 1'b0;
        sbus.en_i = 1'b1; sbus.commit_valid_i = 1'b0; sbus.commit_instr_i = I_ADDI;
        sbus.x7_label_i = LBL; sbus.trap_i = 1'b0; sbus.mret_i = 1'b0; sbus.ex_ack_i = 1'b0;

        //               rst  en   cv   instr     x7        trap mret ack   elp  pelp exv  cnt
        vq.push_back(mk(1'b1,1'b1,1'b0,I_ADDI,  LBL,      1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,16'd0));
        vq.push_back(mk(1'b0,1'b1,1'b1,I_JALR6, LBL,      1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0,16'd0));
        vq.push_back(mk(1'b0,1'b1,1'b1,I_LPAD,  LBL,      1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,16'd0));
        vq.push_back(mk(1'b0,1'b1,1'b1,I_LPAD,  LBL,      1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,16'd0));
        vq.push_back(mk(1'b0,1'b1,1'b1,I_RET,   LBL,      1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,16'd0));
        vq.push_back(mk(1'b0,1'b1,1'b1,I_JALR5, LBL,      1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,16'd0));
        vq.push_back(mk(1'b0,1'b1,1'b1,I_JALR7, LBL,      1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,16'd0));
        vq.push_back(mk(1'b0,1'b1,1'b1,I_JALR6, LBL,      1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0,16'd0));
        vq.push_back(mk(1'b0,1'b1,1'b0,I_ADDI,  LBL,      1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0,16'd0));
        vq.push_back(mk(1'b0,1'b1,1'b0,I_ADDI,  LBL,      1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0,16'd0));
        vq.push_back(mk(1'b0,1'b1,1'b1,I_LPAD0, LBL,      1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,16'd0));
        vq.push_back(mk(1'b0,1'b1,1'b1,I_JALR6, LBL,      1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0,16'd0));
        vq.push_back(mk(1'b0,1'b1,1'b1,I_ADDI,  LBL,      1'b0,1'b0,1'b0, 1'b1,1'b0,1'b1,16'd1));
        vq.push_back(mk(1'b0,1'b1,1'b1,I_JALR6, LBL,      1'b0,1'b0,1'b0, 1'b1,1'b0,1'b1,16'd1));
        vq.push_back(mk(1'b0,1'b1,1'b0,I_ADDI,  LBL,      1'b1,1'b0,1'b0, 1'b1,1'b0,1'b1,16'd1));
        vq.push_back(mk(1'b0,1'b1,1'b0,I_ADDI,  LBL,      1'b0,1'b1,1'b1, 1'b0,1'b1,1'b0,16'd1));
        vq.push_back(mk(1'b0,1'b1,1'b0,I_ADDI,  LBL,      1'b0,1'b1,1'b0, 1'b1,1'b0,1'b0,16'd1));
        vq.push_back(mk(1'b0,1'b1,1'b1,I_LPAD,  LBL,      1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,16'd1));
        vq.push_back(mk(1'b0,1'b1,1'b1,I_JALR6, LBL,      1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0,16'd1));
        vq.push_back(mk(1'b0,1'b1,1'b1,I_LPAD,  LBL,      1'b1,1'b1,1'b0, 1'b0,1'b1,1'b0,16'd1));
        vq.push_back(mk(1'b0,1'b1,1'b0,I_ADDI,  LBL,      1'b0,1'b1,1'b0, 1'b1,1'b0,1'b0,16'd1));
        vq.push_back(mk(1'b0,1'b1,1'b0,I_ADDI,  LBL,      1'b0,1'b1,1'b0, 1'b0,1'b0,1'b0,16'd1));
        vq.push_back(mk(1'b0,1'b1,1'b1,I_JALR6, LBL,      1'b0,1'b1,1'b0, 1'b0,1'b0,1'b0,16'd1));
        vq.push_back(mk(1'b0,1'b1,1'b1,I_JALR6, LBL,      1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0,16'd1));
        vq.push_back(mk(1'b0,1'b1,1'b1,I_AUIPC5,LBL,      1'b0,1'b0,1'b0, 1'b1,1'b0,1'b1,16'd2));
        vq.push_back(mk(1'b0,1'b1,1'b0,I_ADDI,  LBL,      1'b0,1'b0,1'b1, 1'b0,1'b1,1'b0,16'd2));
        vq.push_back(mk(1'b0,1'b1,1'b1,I_JALR6, LBL,      1'b0,1'b0,1'b0, 1'b1,1'b1,1'b0,16'd2));
        vq.push_back(mk(1'b0,1'b1,1'b1,I_LPAD1, 20'h00002,1'b0,1'b0,1'b0, 1'b1,1'b1,1'b1,16'd3));
        vq.push_back(mk(1'b0,1'b1,1'b0,I_ADDI,  LBL,      1'b0,1'b0,1'b1, 1'b0,1'b1,1'b0,16'd3));
        vq.push_back(mk(1'b0,1'b1,1'b1,I_JALR6, LBL,      1'b0,1'b0,1'b0, 1'b1,1'b1,1'b0,16'd3));
        vq.push_back(mk(1'b0,1'b0,1'b1,I_ADDI,  LBL,      1'b0,1'b0,1'b0, 1'b0,1'b1,1'b0,16'd3));
        vq.push_back(mk(1'b0,1'b0,1'b1,I_JALR6, LBL,      1'b0,1'b0,1'b0, 1'b0,1'b1,1'b0,16'd3));
        vq.push_back(mk(1'b0,1'b1,1'b1,I_ADDI,  LBL,      1'b0,1'b0,1'b0, 1'b0,1'b1,1'b0,16'd3));
        vq.push_back(mk(1'b0,1'b1,1'b1,I_JALR6, LBL,      1'b0,1'b0,1'b0, 1'b1,1'b1,1'b0,16'd3));
        vq.push_back(mk(1'b0,1'b1,1'b1,I_LPAD,  20'h54321,1'b0,1'b0,1'b0, 1'b1,1'b1,1'b1,16'd4));
        vq.push_back(mk(1'b1,1'b1,1'b0,I_ADDI,  LBL,      1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,16'd0));
        vq.push_back(mk(1'b0,1'b0,1'b0,I_ADDI,  LBL,      1'b1,1'b0,1'b0, 1'b0,1'b0,1'b0,16'd0));

        for (int i = 0; i < vq.size(); i++) begin
            rst                = vq[i].rst;
            bus.en_i           = vq[i].en;
            bus.commit_valid_i = vq[i].cv;
            bus.commit_instr_i = vq[i].instr;
            bus.x7_label_i     = vq[i].x7;
            bus.trap_i         = vq[i].trap;
            bus.mret_i         = vq[i].mret;
            bus.ex_ack_i       = vq[i].ack;
            @(posedge clk);
            #1;
            chk_out($sformatf("vec%0d", i), bus.elp_o, bus.pelp_o, bus.ex_valid_o, bus.ex_cause_o,
                    bus.ex_tval_o, bus.viol_cnt_o,
                    vq[i].e_elp, vq[i].e_pelp, vq[i].e_exv, vq[i].e_cnt);
        end

        // Saturation: counter preloaded near the top, three more faults must stop at FFFF.
        sstep(1'b0, I_ADDI, 1'b0);
        rst_sat = 1'b0;
        chk_out("sat_rst", sbus.elp_o, sbus.pelp_o, sbus.ex_valid_o, sbus.ex_cause_o,
                sbus.ex_tval_o, sbus.viol_cnt_o, 1'b0, 1'b0, 1'b0, 16'hFFFD);
        for (int k = 0; k < 3; k++) begin
            logic [15:0] exp_cnt;
            exp_cnt = (k == 0) ? 16'hFFFE : 16'hFFFF;
            sstep(1'b1, I_JALR6, 1'b0);
            sstep(1'b1, I_ADDI, 1'b0);
            chk_out($sformatf("sat_fault%0d", k), sbus.elp_o, sbus.pelp_o, sbus.ex_valid_o,
                    sbus.ex_cause_o, sbus.ex_tval_o, sbus.viol_cnt_o, 1'b1, (k != 0), 1'b1, exp_cnt);
            for (int h = 0; h < 2; h++) begin
                sstep(1'b0, I_ADDI, 1'b0);
                chk($sformatf("sat_hold%0d_%0d exv", k, h), {31'd0, sbus.ex_valid_o}, 32'd1);
            end
            sstep(1'b0, I_ADDI, 1'b1);
            chk_out($sformatf("sat_ack%0d", k), sbus.elp_o, sbus.pelp_o, sbus.ex_valid_o,
                    sbus.ex_cause_o, sbus.ex_tval_o, sbus.viol_cnt_o, 1'b0, 1'b1, 1'b0, exp_cnt);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
